// File: rtl/am_envelope_demod_if.sv
// Streaming bus for the AM envelope demodulator: carrier samples in, audio samples out.
// The master side drives samples and sink readiness; the slave side is the demodulator.
interface am_envelope_demod_if #(
  parameter int unsigned DW = 16
) ();
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/am_envelope_demod.sv
// AM envelope demodulator: saturating rectifier, integrate-and-dump over 2^LOG2_DEC samples,
// leaky DC tracker removing the carrier level, and a single-entry valid/ready output register.
module am_envelope_demod #(
  parameter int unsigned DW       = 16,
  parameter int unsigned LOG2_DEC = 4,
  parameter int unsigned DC_SHIFT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  am_envelope_demod_if.slave   bus,
  output logic                 overflow,
  output logic                 locked
);

  localparam int unsigned MW = DW - 1;
  localparam int unsigned AW = MW + LOG2_DEC;
  localparam int unsigned CW = MW + DC_SHIFT;
  localparam logic [LOG2_DEC-1:0] CntLast = '1;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       acc_q, acc_d;
  logic [LOG2_DEC-1:0] cnt_q, cnt_d;
  logic [MW-1:0]       env_q, env_d;
  logic                env_v_q, env_v_d;
  logic [CW-1:0]       dc_full_q, dc_full_d;
  logic                out_valid_q, out_valid_d;
  logic [DW-1:0]       out_data_q, out_data_d;
  logic                overflow_q, overflow_d;

  logic [MW-1:0] mag;
  logic [AW-1:0] sum;
  logic [MW-1:0] dc_int;
  logic [DW-1:0] result;
  logic          res_v;

  // Negate only the magnitude bits; the most negative code saturates to full scale.
  always_comb begin
    if (!bus.in_data[DW-1]) begin
      mag = bus.in_data[MW-1:0];
    end else if (bus.in_data[MW-1:0] == '0) begin
      mag = '1;
    end else begin
      mag = ~bus.in_data[MW-1:0] + 1'b1;
    end
  end

  assign sum = acc_q + AW'(mag);

  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    env_d   = env_q;
    env_v_d = 1'b0;
    if (bus.in_valid) begin
      if (cnt_q == CntLast) begin
        acc_d   = '0;
        cnt_d   = '0;
        env_d   = sum[AW-1:LOG2_DEC];
        env_v_d = 1'b1;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign dc_int = dc_full_q[CW-1:DC_SHIFT];
  // Both operands are non-negative and below 2^(DW-1), so the difference fits in DW bits.
  assign result = {1'b0, env_q} - {1'b0, dc_int};

  always_comb begin
    state_d   = state_q;
    dc_full_d = dc_full_q;
    res_v     = 1'b0;
    unique case (state_q)
      StInit: begin
        if (env_v_q) begin
          dc_full_d = CW'(env_q) << DC_SHIFT;
          state_d   = StRun;
        end
      end
      StRun: begin
        if (env_v_q) begin
          res_v     = 1'b1;
          dc_full_d = dc_full_q + CW'(env_q) - CW'(dc_int);
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    overflow_d  = overflow_q;
    if (res_v) begin
      if (!out_valid_q || bus.out_ready) begin
        out_valid_d = 1'b1;
        out_data_d  = result;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StInit;
      acc_q       <= '0;
      cnt_q       <= '0;
      env_q       <= '0;
      env_v_q     <= 1'b0;
      dc_full_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
    end else if (clear) begin
      state_q     <= StInit;
      acc_q       <= '0;
      cnt_q       <= '0;
      env_q       <= '0;
      env_v_q     <= 1'b0;
      dc_full_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      env_q       <= env_d;
      env_v_q     <= env_v_d;
      dc_full_q   <= dc_full_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign overflow      = overflow_q;
  assign locked        = (state_q == StRun);

endmodule
